// File: rtl/bus_share_rr_arbiter.sv
// bus_share_rr_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one DATA_W-bit
//   data bus. Grants are burst-oriented: a grant ends on the requester's last
//   beat or after MAX_BURST beats, whichever comes first. One IDLE cycle
//   always separates grants, and that cycle is used for arbitration.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NUM_REQ]         per-requester beat valid
//   req_last   in   [NUM_REQ]         per-requester last beat of packet
//   req_data   in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         accept to the granted requester only
//   out_valid  out                    beat valid to the shared bus
//   out_data   out  [DATA_W]          beat data to the shared bus
//   out_last   out                    final beat of the current grant
//   out_ready  in                     shared bus accepts the beat
//   grant_id   out  [clog2(NUM_REQ)]  current / most recent grantee
//   busy       out                    high while a grant is active
module bus_share_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          xfer;

  // Rotating-priority search: first valid requester at or after
  // last_grant+1, wrapping modulo NUM_REQ (works for non-power-of-2 counts).
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  // Bus mux: purely combinational so stalls pass data straight through.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    xfer      = 1'b0;
    if (state_q == GRANT) begin
      busy               = 1'b1;
      out_valid          = req_valid[grant_q];
      out_data           = req_data[int'(grant_q)*DATA_W +: DATA_W];
      // Forced rotation: the MAX_BURST-th beat closes the grant.
      out_last           = req_last[grant_q] | (beat_cnt_q == LAST_BEAT);
      req_ready[grant_q] = out_ready;
      xfer               = out_valid & out_ready;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped valid or low out_ready simply holds everything here.
        if (xfer) begin
          if (out_last) begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: doc/bus_share_rr_arbiter.md
Name: bus_share_rr_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit data bus between NUM_REQ requesters.
- Uses valid/ready handshakes on both sides.
- Grants are burst-oriented. A grant ends on the requester's last beat or after MAX_BURST beats, whichever comes first.
- Sits in front of the shared IP data input and sequences which requester drives it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data bus width
MAX_BURST, 4, max beats per grant before forced rotation (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester last beat of packet
req_data  input  NUM_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
out_valid  output  1  beat valid to shared bus
out_data  output  DATA_W  beat data to shared bus
out_last  output  1  final beat of current grant
out_ready  input  1  shared bus accepts beat
grant_id  output  $clog2(NUM_REQ)  index of current/last grantee
busy  output  1  high while in GRANT state

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous, active-low, sampled on rising edge.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, req_ready=0, grant_id=0, busy=0.
  - Internal last_grant=NUM_REQ-1, so requester 0 has first priority.
  - beat_cnt=0, state=IDLE.
- IDLE state:
  - busy=0, out_valid=0, req_ready all 0.
  - If any req_valid is high, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register that index into grant_id, go to GRANT.
  - Arbitration latency: 1 cycle; no data moves in the arbitration cycle.
- GRANT state (g = grant_id):
  - busy=1.
  - Combinational mux: out_valid=req_valid[g], out_data=req_data[g].
  - req_ready[g]=out_ready; all other req_ready=0.
  - out_last = req_last[g] OR (beat_cnt == MAX_BURST-1).
  - A beat transfers when out_valid && out_ready.
- Beat counting and release:
  - On each transfer, beat_cnt increments.
  - If out_last was high on that beat: last_grant<=g, beat_cnt<=0, state<=IDLE.
  - One bubble cycle (IDLE) always separates consecutive grants, including re-grant to the same requester.
- Stalls: out_ready low holds the state. beat_cnt and grant are unchanged, data is passed through as-is.
- Requester dropping req_valid mid-grant:
  - The arbiter waits in GRANT, does not rotate, and keeps beat_cnt.
  - Requesters must not drop valid before ready; a violation only stalls the bus.
- Non-granted requesters see req_ready=0 and must hold their beat.
- Forced rotation: out_last is asserted on beat MAX_BURST even if req_last=0. The requester's remaining beats wait for a later grant.
- Simultaneous requests: strict round-robin from last_grant+1. Every requester with valid held is served within NUM_REQ grants.
- Reset asserted mid-burst:
  - Next edge forces all reset values. The in-flight beat is dropped and no transfer is counted.
  - Outputs low from that cycle on; rotation restarts at requester 0.
- grant_id holds its value in IDLE until the next arbitration.

Test Plan:
1. Reset then single request: req_valid=4'b0100, 3 beats with data 0x11,0x22,0x33, last on 3rd, out_ready=1 -> grant_id=2 after 1 cycle; out_data 0x11,0x22,0x33 on 3 consecutive cycles; out_last only on 0x33; busy drops next cycle.
2. All four requesting continuously, each 1-beat packet, out_ready=1 -> grant order 0,1,2,3,0; each beat separated by exactly one IDLE cycle; req_ready one-hot matching grant_id.
3. Requester 1 sends 7-beat packet with MAX_BURST=4, requester 3 waiting:
   - Beats 1-4 go out with out_last on beat 4.
   - Requester 3 is granted next.
   - Requester 1 then regains the grant and finishes beats 5-7, out_last on beat 7.
4. Backpressure: grant to requester 0, out_ready toggles 1,0,0,1 over 4-beat packet -> beat 2 held stable for 3 cycles, req_ready[0] mirrors out_ready, beat_cnt advances only on accepted beats, total 6 active cycles.
5. Reset mid-burst: assert rst_n=0 after 2 of 4 beats from requester 2 -> next cycle out_valid=0, busy=0, grant_id=0; after release with req 2 and 3 valid, requester 2 granted first (rotation restarted).
6. Mid-grant valid drop: requester 0 granted, deasserts req_valid for 2 cycles after beat 1 while requester 1 valid -> grant stays 0, out_valid=0 for those cycles, no switch to requester 1 until requester 0 delivers last beat.
